// File: rtl/decoded_reg_file.sv
// decoded_reg_file: N = 2**ADDR_W entry register file with one write port
// and two combinational read ports. Each port is addressed through an
// explicit one-hot wordline that is also exported.
// Build option: define DECODED_REG_FILE_BYPASS_EN to forward DstData to a
// read port that matches the in-flight write in the same cycle.
module decoded_reg_file #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      WriteReg,
  input  logic [ADDR_W-1:0]         DstReg,
  input  logic [DATA_W-1:0]         DstData,
  input  logic [ADDR_W-1:0]         SrcReg1,
  input  logic [ADDR_W-1:0]         SrcReg2,
  output logic [DATA_W-1:0]         SrcData1,
  output logic [DATA_W-1:0]         SrcData2,
  output logic [(1 << ADDR_W)-1:0]  RdWordline1,
  output logic [(1 << ADDR_W)-1:0]  RdWordline2,
  output logic [(1 << ADDR_W)-1:0]  WrWordline
);

  localparam int unsigned N       = 1 << ADDR_W;
  localparam bit          ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] entry [N];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              byp1;
  logic              byp2;

  // One-hot decode: bit k set iff idx == k. An X index yields X bits, which
  // the write enable below treats as "not selected".
  function automatic logic [N-1:0] decode(input logic [ADDR_W-1:0] idx);
    logic [N-1:0] wl;
    wl = '0;
    for (int unsigned k = 0; k < N; k++) begin
      wl[k] = (idx == ADDR_W'(k));
    end
    return wl;
  endfunction

  // Read wordlines decode their index unconditionally, including in reset.
  always_comb begin
    RdWordline1 = decode(SrcReg1);
    RdWordline2 = decode(SrcReg2);
  end

  // Write wordline: gated by WriteReg; entry 0 is never selected when hardwired.
  always_comb begin
    WrWordline = '0;
    if (WriteReg) begin
      WrWordline = decode(DstReg);
    end
    if (ZERO_EN) begin
      WrWordline[0] = 1'b0;
    end
  end

  // Storage: async clear of every entry; a write loads only the selected entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        entry[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (WrWordline[k]) begin
          entry[k] <= DstData;
        end
      end
    end
  end

  // Bypass match: the write wordline already excludes index 0 when hardwired,
  // so overlap with a read wordline is exactly the forwarding condition.
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef DECODED_REG_FILE_BYPASS_EN
    byp1 = rst_n && (|(WrWordline & RdWordline1));
    byp2 = rst_n && (|(WrWordline & RdWordline2));
`endif
  end

  // Read ports: AND-OR mux over the wordline, optional forward, zero-reg gate last.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int unsigned k = 0; k < N; k++) begin
      rd1 = rd1 | ({DATA_W{RdWordline1[k]}} & entry[k]);
      rd2 = rd2 | ({DATA_W{RdWordline2[k]}} & entry[k]);
    end
    if (byp1) begin
      rd1 = DstData;
    end
    if (byp2) begin
      rd2 = DstData;
    end
    if (ZERO_EN && (SrcReg1 == '0)) begin
      rd1 = '0;
    end
    if (ZERO_EN && (SrcReg2 == '0)) begin
      rd2 = '0;
    end
    SrcData1 = rd1;
    SrcData2 = rd2;
  end

endmodule

// File: doc/decoded_reg_file.md
DECODED_REG_FILE -- requirements
Module: decoded_reg_file

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, register-index width; entry count N = 2^ADDR_W.
REQ-002 The block SHALL have parameter DATA_W, default 16, register data width.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 The block SHALL have port WriteReg, input, 1, write enable.
REQ-007 The block SHALL have port DstReg, input, ADDR_W, write index.
REQ-008 The block SHALL have port DstData, input, DATA_W, write data.
REQ-009 The block SHALL have ports SrcReg1 and SrcReg2, input, ADDR_W each, read indices.
REQ-010 The block SHALL have ports SrcData1 and SrcData2, output, DATA_W each, read data.
REQ-011 The block SHALL have ports RdWordline1 and RdWordline2, output, N each, one-hot decode of SrcReg1 and SrcReg2.
REQ-012 The block SHALL have port WrWordline, output, N, one-hot decode of DstReg gated by WriteReg.

Function
REQ-013 Decode SHALL be parametrised: bit k of a wordline is 1 iff index == k; exactly one bit set for every index 0..N-1, including N-1.
REQ-014 WrWordline SHALL be all-zero when WriteReg=0; when ZERO_REG=1, bit 0 SHALL be forced to 0.
REQ-015 On a rising clk with WriteReg=1, the entry selected by WrWordline SHALL load DstData; all other entries hold.
REQ-016 Reads SHALL be combinational: SrcDataX = entry selected by RdWordlineX, zero latency, no clock needed.
REQ-017 With ZERO_REG=1, SrcDataX SHALL be 0 whenever SrcRegX == 0, regardless of writes or bypass.
REQ-018 Both read ports SHALL be independent; SrcReg1 == SrcReg2 returns identical data on both.
REQ-019 A write and a read of the same index in the same cycle SHALL follow REQ-030/REQ-031.
REQ-020 Unknown (X) index inputs SHALL NOT corrupt unselected entries; writes occur only through a valid one-hot WrWordline.

Reset
REQ-021 While rst_n=0, all N entries SHALL be 0, asynchronously, independent of clk.
REQ-022 During reset, SrcData1/SrcData2 SHALL read 0; wordline outputs SHALL still decode their inputs.
REQ-023 Reset asserted in the same cycle as a write SHALL win; the entry SHALL read 0 after the edge.
REQ-024 After rst_n deasserts, the first rising clk with WriteReg=1 SHALL perform a normal write.

Configuration
REQ-025 The block SHALL use macro DECODED_REG_FILE_BYPASS_EN to compile write-to-read bypass in or out.
REQ-026 Only the bypass path SHALL differ between the two builds; ports and parameters SHALL be identical.
REQ-027 The bypass condition SHALL be WriteReg=1 and SrcRegX == DstReg, excluding index 0 when ZERO_REG=1.
REQ-028 A bypass SHALL never be taken while rst_n=0.
REQ-029 Bypass on one read port SHALL NOT affect the other.
REQ-030 With the macro defined and the bypass condition true, SrcDataX SHALL equal DstData in the same cycle, before the clock edge.
REQ-031 Without the macro, SrcDataX SHALL show the old stored value until the edge and the new value after it.

Verification
REQ-032 Reset check: rst_n=0 mid-cycle after writing 0xBEEF to R5 -> SrcData1 (SrcReg1=5) = 0x0000 immediately, without a clock edge.
REQ-033 Write/read check: write 0x1234 to R3, then set SrcReg1=3 and SrcReg2=15 with R15=0xA5A5 -> SrcData1=0x1234, SrcData2=0xA5A5, RdWordline2=0x8000.
REQ-034 Zero-register check: ZERO_REG=1, write 0xFFFF to R0 -> WrWordline=0x0000 and SrcData1 (SrcReg1=0) = 0x0000.
REQ-035 Bypass check: R7=0x0011, WriteReg=1, DstReg=7, DstData=0x00AA, SrcReg1=7 before the edge -> SrcData1=0x00AA with the macro, 0x0011 without; 0x00AA on both builds after the edge.
REQ-036 Parameter sweep: ADDR_W=5, DATA_W=32 -> write index 31 with 0xDEADBEEF; RdWordline1 bit 31 only, and readback matches.
REQ-037 Exhaustive decode check: for every index 0..N-1 -> each wordline equals 1<<index; WrWordline=0 when WriteReg=0.
